// File: rtl/mips_reg_file_if.sv
// rtl/mips_reg_file_if.sv - decode/write-back bus for the MIPS register file
interface mips_reg_file_if;
    logic        flush;
    logic        wb_write_enable;
    logic [4:0]  wb_write_addr;
    logic [31:0] wb_write_data;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        rs_busy;
    logic        rt_busy;
    logic        issue_valid;
    logic [4:0]  issue_dest;
    logic        issue_ready;

    // Pipeline side: drives write-back, read addresses and issue requests.
    modport master (
        output flush, wb_write_enable, wb_write_addr, wb_write_data,
        output rs_addr, rt_addr, issue_valid, issue_dest,
        input  rs_data, rt_data, rs_busy, rt_busy, issue_ready
    );

    // Register file side.
    modport slave (
        input  flush, wb_write_enable, wb_write_addr, wb_write_data,
        input  rs_addr, rt_addr, issue_valid, issue_dest,
        output rs_data, rt_data, rs_busy, rt_busy, issue_ready
    );
endinterface

// File: rtl/mips_reg_file.sv
// rtl/mips_reg_file.sv - 32x32 MIPS register file with bypass and pending-write scoreboard (trace: MIPS_REG_FILE_TRACE_EN)
module mips_reg_file #(
    parameter int          PEND_W  = 2,
    parameter logic [31:0] SP_INIT = 32'h0000_3FFC,
    parameter logic [31:0] GP_INIT = 32'h0000_1800
) (
    input logic            clk,
    input logic            rst,
    mips_reg_file_if.slave bus
);
    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [31:0]       regs_q [32];
    logic [PEND_W-1:0] cnt_q  [32];
    logic [PEND_W-1:0] cnt_d  [32];

    logic        wb_hit;
    logic        issue_acc;
    logic [31:0] issue_hit;
    logic [31:0] retire_hit;

    // A write-back to a non-zero register is both a data write and a retire attempt.
    assign wb_hit = bus.wb_write_enable && (bus.wb_write_addr != 5'd0);

    // Reads: r0 is hardwired zero; same-cycle write-back bypasses the array.
    assign bus.rs_data = (bus.rs_addr == 5'd0) ? 32'd0 :
                         (wb_hit && bus.wb_write_addr == bus.rs_addr) ? bus.wb_write_data :
                         regs_q[bus.rs_addr];
    assign bus.rt_data = (bus.rt_addr == 5'd0) ? 32'd0 :
                         (wb_hit && bus.wb_write_addr == bus.rt_addr) ? bus.wb_write_data :
                         regs_q[bus.rt_addr];

    // A retiring write this cycle is covered by bypass, so only writes beyond it count as busy.
    assign bus.rs_busy = (wb_hit && bus.wb_write_addr == bus.rs_addr) ?
                         (cnt_q[bus.rs_addr] > PEND_W'(1)) : (cnt_q[bus.rs_addr] != '0);
    assign bus.rt_busy = (wb_hit && bus.wb_write_addr == bus.rt_addr) ?
                         (cnt_q[bus.rt_addr] > PEND_W'(1)) : (cnt_q[bus.rt_addr] != '0);

    // A full counter still accepts an issue when a retire to the same register frees a slot.
    assign bus.issue_ready = (bus.issue_dest == 5'd0) ||
                             (cnt_q[bus.issue_dest] != CNT_MAX) ||
                             (wb_hit && bus.wb_write_addr == bus.issue_dest);

    assign issue_acc = bus.issue_valid && bus.issue_ready && !bus.flush;

    // One-hot issue and retire strobes per register; r0 never counts.
    always_comb begin
        issue_hit  = '0;
        retire_hit = '0;
        for (int r = 1; r < 32; r++) begin
            issue_hit[r]  = issue_acc && (bus.issue_dest == 5'(r));
            retire_hit[r] = wb_hit && (bus.wb_write_addr == 5'(r)) && (cnt_q[r] != '0);
        end
    end

    // Next counter values: flush clears, otherwise issue/retire net out.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            cnt_d[r] = cnt_q[r];
        end
        for (int r = 1; r < 32; r++) begin
            if (bus.flush) begin
                cnt_d[r] = '0;
            end else if (issue_hit[r] && !retire_hit[r]) begin
                cnt_d[r] = cnt_q[r] + PEND_W'(1);
            end else if (retire_hit[r] && !issue_hit[r]) begin
                cnt_d[r] = cnt_q[r] - PEND_W'(1);
            end
        end
        cnt_d[0] = '0;
    end

    // Scoreboard counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Register array write port; flush does not block the write-back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < 32; r++) begin
                regs_q[r] <= 32'd0;
            end
            regs_q[28] <= GP_INIT;
            regs_q[29] <= SP_INIT;
        end else if (wb_hit) begin
            regs_q[bus.wb_write_addr] <= bus.wb_write_data;
        end
    end

`ifdef MIPS_REG_FILE_TRACE_EN
`ifndef SYNTHESIS
    // Simulation trace of writes and underflowing retires.
    always @(posedge clk) begin
        if (rst && wb_hit) begin
            $display("R%0d <= 0x%08h", bus.wb_write_addr, bus.wb_write_data);
            if (cnt_q[bus.wb_write_addr] == '0) begin
                $display("regfile: retire underflow r%0d", bus.wb_write_addr);
            end
        end
    end
`endif
`endif
endmodule

// File: tb/tb_mips_reg_file.sv
// tb/tb_mips_reg_file.sv - self-checking bench for mips_reg_file
module tb_mips_reg_file;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    int unsigned m_regs [32];
    int          m_cnt  [32];
    localparam int MAXC = 3;

    mips_reg_file_if bus ();

    mips_reg_file #(.PEND_W(2), .SP_INIT(32'h0000_3FFC), .GP_INIT(32'h0000_1800)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = 0;
            m_cnt[r]  = 0;
        end
        m_regs[28] = 32'h0000_1800;
        m_regs[29] = 32'h0000_3FFC;
    endtask

    function automatic logic retiring(input logic [4:0] a);
        return bus.wb_write_enable && bus.wb_write_addr == a && a != 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (retiring(a)) return bus.wb_write_data;
        return m_regs[a];
    endfunction

    function automatic logic m_busy(input logic [4:0] a);
        return m_cnt[a] > (retiring(a) ? 1 : 0);
    endfunction

    function automatic logic m_ready();
        return bus.issue_dest == 0 || m_cnt[bus.issue_dest] < MAXC || retiring(bus.issue_dest);
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".rs_data"}, bus.rs_data, m_read(bus.rs_addr));
        chk({tag, ".rt_data"}, bus.rt_data, m_read(bus.rt_addr));
        chk({tag, ".rs_busy"}, 32'(bus.rs_busy), 32'(m_busy(bus.rs_addr)));
        chk({tag, ".rt_busy"}, 32'(bus.rt_busy), 32'(m_busy(bus.rt_addr)));
        chk({tag, ".ready"}, 32'(bus.issue_ready), 32'(m_ready()));
    endtask

    // Advance one clock, updating the model from the inputs held before the edge.
    task automatic tick();
        logic issue_ok;
        logic ret_ok;
        logic [4:0] wa, d;
        wa = bus.wb_write_addr;
        d  = bus.issue_dest;
        issue_ok = !bus.flush && bus.issue_valid && m_ready() && d != 0;
        ret_ok   = retiring(wa) && m_cnt[wa] > 0;
        @(posedge clk);
        if (bus.wb_write_enable && wa != 0) m_regs[wa] = bus.wb_write_data;
        if (bus.flush) begin
            for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        end else begin
            if (ret_ok)   m_cnt[wa] = m_cnt[wa] - 1;
            if (issue_ok) m_cnt[d]  = m_cnt[d] + 1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        bus.flush = 0; bus.wb_write_enable = 0; bus.wb_write_addr = 0; bus.wb_write_data = 0;
        bus.issue_valid = 0; bus.issue_dest = 0;
    endtask

    initial begin
        idle();
        bus.rs_addr = 29; bus.rt_addr = 28;
        model_reset();
        #12;
        // Reset values while held in reset
        chk("rst.sp", bus.rs_data, 32'h0000_3FFC);
        chk("rst.gp", bus.rt_data, 32'h0000_1800);
        chk("rst.rs_busy", 32'(bus.rs_busy), 32'd0);
        chk("rst.rt_busy", 32'(bus.rt_busy), 32'd0);
        chk("rst.ready", 32'(bus.issue_ready), 32'd1);
        for (int a = 0; a < 28; a++) begin
            bus.rs_addr = 5'(a); #1;
            chk("rst.zero", bus.rs_data, 32'd0);
        end
        bus.rs_addr = 30; bus.rt_addr = 31; #1;
        chk("rst.r30", bus.rs_data, 32'd0);
        chk("rst.r31", bus.rt_data, 32'd0);
        @(negedge clk);
        rst = 1;

        // Write r8 with bypass, then after the edge
        bus.wb_write_enable = 1; bus.wb_write_addr = 8; bus.wb_write_data = 32'hDEADBEEF;
        bus.rs_addr = 8; #1;
        chk("wr8.bypass", bus.rs_data, 32'hDEADBEEF);
        tick(); idle(); #1;
        chk("wr8.stored", bus.rs_data, 32'hDEADBEEF);
        bus.wb_write_enable = 1; bus.wb_write_addr = 0; bus.wb_write_data = 5;
        bus.rs_addr = 0; #1;
        chk("wr0.bypass", bus.rs_data, 32'd0);
        tick(); idle(); #1;
        chk("wr0.stored", bus.rs_data, 32'd0);

        // Two issues to r9 then two retires
        bus.issue_valid = 1; bus.issue_dest = 9;
        tick(); tick(); idle();
        bus.rs_addr = 9; #1;
        chk("r9.busy2", 32'(bus.rs_busy), 32'd1);
        bus.wb_write_enable = 1; bus.wb_write_addr = 9; bus.wb_write_data = 32'h1111_0009; #1;
        chk("r9.retire1", 32'(bus.rs_busy), 32'd1);
        tick();
        bus.wb_write_data = 32'h2222_0009; #1;
        chk("r9.retire2.busy", 32'(bus.rs_busy), 32'd0);
        chk("r9.retire2.data", bus.rs_data, 32'h2222_0009);
        check_all("r9");
        tick(); idle();

        // Saturate r10
        bus.issue_valid = 1; bus.issue_dest = 10;
        tick(); tick(); tick(); #1;
        chk("r10.full", 32'(bus.issue_ready), 32'd0);
        tick(); idle(); bus.issue_dest = 10; bus.rs_addr = 10; #1;
        chk("r10.still_full", 32'(bus.issue_ready), 32'd0);
        bus.issue_valid = 1; bus.wb_write_enable = 1; bus.wb_write_addr = 10; bus.wb_write_data = 32'hA; #1;
        chk("r10.swap_ready", 32'(bus.issue_ready), 32'd1);
        chk("r10.swap_busy", 32'(bus.rs_busy), 32'd1);
        tick(); idle(); bus.issue_dest = 10; #1;
        chk("r10.after_swap", 32'(bus.issue_ready), 32'd0);
        chk("r10.model_cnt", 32'(m_cnt[10]), 32'd3);

        // Flush with a concurrent write
        bus.issue_valid = 1; bus.issue_dest = 11; tick();
        bus.issue_dest = 12; tick(); idle();
        bus.flush = 1; bus.wb_write_enable = 1; bus.wb_write_addr = 13; bus.wb_write_data = 7;
        bus.issue_valid = 1; bus.issue_dest = 14;
        tick(); idle();
        bus.rs_addr = 11; bus.rt_addr = 12; #1;
        chk("flush.r11", 32'(bus.rs_busy), 32'd0);
        chk("flush.r12", 32'(bus.rt_busy), 32'd0);
        bus.rs_addr = 13; bus.rt_addr = 14; #1;
        chk("flush.r13", bus.rs_data, 32'd7);
        chk("flush.r14_ignored", 32'(bus.rt_busy), 32'd0);

        // Mid-cycle asynchronous reset
        bus.wb_write_enable = 1; bus.wb_write_addr = 5; bus.wb_write_data = 1;
        bus.issue_valid = 1; bus.issue_dest = 10;
        tick(); idle();
        bus.rs_addr = 5; bus.rt_addr = 10; bus.issue_dest = 10; #1;
        chk("prerst.r5", bus.rs_data, 32'd1);
        #2 rst = 0; #1;
        model_reset();
        chk("arst.r5", bus.rs_data, 32'd0);
        chk("arst.r10_busy", 32'(bus.rt_busy), 32'd0);
        chk("arst.ready", 32'(bus.issue_ready), 32'd1);
        @(negedge clk);
        rst = 1;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            bus.flush           = ($urandom_range(0, 19) == 0);
            bus.wb_write_enable = $urandom_range(0, 1);
            bus.wb_write_addr   = 5'($urandom_range(0, 6));
            bus.wb_write_data   = $urandom;
            bus.issue_valid     = ($urandom_range(0, 3) != 0);
            bus.issue_dest      = 5'($urandom_range(0, 6));
            bus.rs_addr         = 5'($urandom_range(0, 7));
            bus.rt_addr         = ($urandom_range(0, 3) == 0) ? bus.rs_addr : 5'($urandom_range(0, 31));
            #1;
            check_all("rand");
            tick();
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
